// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//   Fetch stage that sits directly upstream of the control FSM. It holds the
//   program counter, reads instruction memory over a req/ack handshake and
//   latches the returned word into the instruction register. When control
//   strobes next_req, the PC advances according to pc_sel. This block does no
//   opcode decode; every word is passed through unchanged.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   next_req     strobe from control: consume instruction, advance PC
//   pc_sel       PC source: 00 refetch, 01 PC+1, 10 gamma, 11 halt
//   gamma        jump target, sampled with next_req when pc_sel=10
//   imem_req     registered memory read request
//   imem_addr    read address (always equal to pc)
//   imem_ack     one-cycle read-data-valid from memory
//   imem_rdata   memory read data, captured when imem_ack is high
//   instruction  instruction register driving the control unit
//   instr_valid  instruction register holds an unconsumed word
//   pc           current program counter
//   halted       fetch stopped by halt select or by memory timeout
//   fetch_err    sticky memory-timeout flag
// ---------------------------------------------------------------------------
module instr_fetch #(
  parameter int unsigned PC_W    = 6,
  parameter int unsigned INSTR_W = 20,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               next_req,
  input  logic [1:0]         pc_sel,
  input  logic [PC_W-1:0]    gamma,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_valid,
  output logic [PC_W-1:0]    pc,
  output logic               halted,
  output logic               fetch_err
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] SEL_REFETCH = 2'b00;
  localparam logic [1:0] SEL_INC     = 2'b01;
  localparam logic [1:0] SEL_JUMP    = 2'b10;

  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_REQ   = 2'd1,
    S_VALID = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic                 valid_q, valid_d;
  logic                 req_q, req_d;
  logic                 halted_q, halted_d;
  logic                 err_q, err_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_START;
      pc_q     <= '0;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      req_q    <= 1'b0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      req_q    <= req_d;
      halted_q <= halted_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    req_d    = req_q;
    halted_d = halted_q;
    err_d    = err_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      S_START: begin
        req_d   = 1'b1;
        state_d = S_REQ;
      end

      S_REQ: begin
        // Ack is checked before the timeout threshold so a response that
        // lands on the final allowed cycle is still accepted.
        if (imem_ack) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          req_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_VALID;
        end else if (cnt_q == CNT_LAST) begin
          req_d    = 1'b0;
          err_d    = 1'b1;
          halted_d = 1'b1;
          cnt_d    = '0;
          state_d  = S_HALT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_VALID: begin
        if (next_req) begin
          // The instruction register is left untouched; only the valid
          // flag drops until the next word arrives.
          valid_d = 1'b0;
          case (pc_sel)
            SEL_REFETCH: begin
              req_d   = 1'b1;
              state_d = S_REQ;
            end
            SEL_INC: begin
              pc_d    = pc_q + PC_W'(1);
              req_d   = 1'b1;
              state_d = S_REQ;
            end
            SEL_JUMP: begin
              pc_d    = gamma;
              req_d   = 1'b1;
              state_d = S_REQ;
            end
            default: begin
              halted_d = 1'b1;
              state_d  = S_HALT;
            end
          endcase
        end
      end

      S_HALT: begin
        req_d    = 1'b0;
        valid_d  = 1'b0;
        halted_d = 1'b1;
      end

      default: begin
        state_d = S_START;
      end
    endcase
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign halted      = halted_q;
  assign fetch_err   = err_q;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        next_req;
  logic [1:0]  pc_sel;
  logic [5:0]  gamma;
  logic        imem_req;
  logic [5:0]  imem_addr;
  logic        imem_ack;
  logic [19:0] imem_rdata;
  logic [19:0] instruction;
  logic        instr_valid;
  logic [5:0]  pc;
  logic        halted;
  logic        fetch_err;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  instr_fetch #(.PC_W(6), .INSTR_W(20), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .next_req(next_req), .pc_sel(pc_sel),
    .gamma(gamma), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instruction(instruction),
    .instr_valid(instr_valid), .pc(pc), .halted(halted), .fetch_err(fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge while VALID: strobe next_req for one cycle, then
  // confirm the new request and address.
  task automatic advance(input logic [1:0] sel, input logic [5:0] g,
                         input logic [5:0] exp_addr, input string tag);
    next_req = 1'b1;
    pc_sel   = sel;
    gamma    = g;
    @(negedge clk);
    next_req = 1'b0;
    gamma    = 6'($urandom);
    check({tag, "_req"},   32'(imem_req),    32'd1);
    check({tag, "_addr"},  32'(imem_addr),   32'(exp_addr));
    check({tag, "_pc"},    32'(pc),          32'(exp_addr));
    check({tag, "_vld0"},  32'(instr_valid), 32'd0);
  endtask

  // Wait (bounded) for a request, answer it one cycle later with data.
  task automatic serve(input logic [19:0] data, input string tag);
    int unsigned k;
    k = 0;
    while (!imem_req && k < 50) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_reqseen"}, 32'(imem_req), 32'd1);
    imem_ack   = 1'b1;
    imem_rdata = data;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 20'h0;
    check({tag, "_vld"},   32'(instr_valid), 32'd1);
    check({tag, "_instr"}, 32'(instruction), 32'(data));
    check({tag, "_reqlo"}, 32'(imem_req),    32'd0);
  endtask

  initial begin
    int unsigned nreq;
    rst_n = 1'b0; next_req = 1'b0; pc_sel = 2'b00; gamma = '0;
    imem_ack = 1'b0; imem_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_pc",    32'(pc),          32'd0);
    check("rst_req",   32'(imem_req),    32'd0);
    check("rst_vld",   32'(instr_valid), 32'd0);
    check("rst_halt",  32'(halted),      32'd0);
    check("rst_err",   32'(fetch_err),   32'd0);
    check("rst_instr", 32'(instruction), 32'd0);

    // 1: first fetch from address 0
    rst_n = 1'b1;
    @(negedge clk);
    check("t1_req",  32'(imem_req),  32'd1);
    check("t1_addr", 32'(imem_addr), 32'd0);
    serve(20'h4300A, "t1");
    check("t1_pc", 32'(pc), 32'd0);

    // ack outside REQ is ignored
    imem_ack = 1'b1; imem_rdata = 20'hBEEF1;
    @(negedge clk);
    imem_ack = 1'b0;
    check("ack_ign_instr", 32'(instruction), 32'h4300A);
    check("ack_ign_vld",   32'(instr_valid), 32'd1);

    // 2: sequential increments
    for (int i = 1; i <= 3; i++) begin
      advance(2'b01, 6'd0, 6'(i), "t2_inc");
      serve(20'hA0000 | 20'(i), "t2");
    end

    // 3: jump to 37; instruction register keeps old word while waiting
    advance(2'b10, 6'd37, 6'd37, "t3_jmp");
    check("t3_hold_instr", 32'(instruction), 32'hA0003);
    // next_req while in REQ is ignored
    next_req = 1'b1; pc_sel = 2'b10; gamma = 6'd50;
    @(negedge clk);
    next_req = 1'b0;
    @(negedge clk);
    check("t3_wait_vld",  32'(instr_valid), 32'd0);
    check("t3_wait_req",  32'(imem_req),    32'd1);
    check("t3_wait_addr", 32'(imem_addr),   32'd37);
    serve(20'hA0025, "t3");
    check("t3_pc", 32'(pc), 32'd37);

    // 5b: refetch same address
    advance(2'b00, 6'd5, 6'd37, "t5_refetch");
    serve(20'h55555, "t5r");

    // 2b: wrap 63 -> 0
    advance(2'b10, 6'd63, 6'd63, "t2_j63");
    serve(20'hA003F, "t2_63");
    advance(2'b01, 6'd0, 6'd0, "t2_wrap");
    serve(20'hA0000, "t2_w");

    // 6: async reset during an outstanding request
    advance(2'b10, 6'd37, 6'd37, "t6_jmp");
    #2 rst_n = 1'b0;
    #1;
    check("t6_req",  32'(imem_req),    32'd0);
    check("t6_pc",   32'(pc),          32'd0);
    check("t6_vld",  32'(instr_valid), 32'd0);
    check("t6_instr", 32'(instruction), 32'd0);
    @(negedge clk);
    imem_ack = 1'b1; imem_rdata = 20'hFFFFF;
    @(negedge clk);
    imem_ack = 1'b0;
    check("t6_spur_instr", 32'(instruction), 32'd0);
    check("t6_spur_vld",   32'(instr_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_rf_req",  32'(imem_req),  32'd1);
    check("t6_rf_addr", 32'(imem_addr), 32'd0);
    serve(20'h12345, "t6");

    // 5a: halt select
    next_req = 1'b1; pc_sel = 2'b11; gamma = 6'd9;
    @(negedge clk);
    next_req = 1'b0;
    check("t5_halt",   32'(halted),      32'd1);
    check("t5_req",    32'(imem_req),    32'd0);
    check("t5_vld",    32'(instr_valid), 32'd0);
    check("t5_err",    32'(fetch_err),   32'd0);
    next_req = 1'b1; pc_sel = 2'b01; imem_ack = 1'b1; imem_rdata = 20'h77777;
    repeat (2) @(negedge clk);
    next_req = 1'b0; imem_ack = 1'b0;
    check("t5_stay_req",   32'(imem_req),    32'd0);
    check("t5_stay_pc",    32'(pc),          32'd0);
    check("t5_stay_instr", 32'(instruction), 32'h12345);
    check("t5_stay_halt",  32'(halted),      32'd1);

    // ack on the last allowed cycle wins over timeout
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    repeat (15) @(negedge clk);
    check("thr_req", 32'(imem_req), 32'd1);
    imem_ack = 1'b1; imem_rdata = 20'h0ACED;
    @(negedge clk);
    imem_ack = 1'b0;
    check("thr_vld",   32'(instr_valid), 32'd1);
    check("thr_instr", 32'(instruction), 32'h0ACED);
    check("thr_err",   32'(fetch_err),   32'd0);
    check("thr_halt",  32'(halted),      32'd0);

    // 4: memory never answers
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    nreq = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (imem_req) nreq++;
    end
    check("t4_reqcycles", 32'(nreq),      32'd16);
    check("t4_err",       32'(fetch_err), 32'd1);
    check("t4_halt",      32'(halted),    32'd1);
    next_req = 1'b1; pc_sel = 2'b01; imem_ack = 1'b1; imem_rdata = 20'h31415;
    repeat (2) @(negedge clk);
    next_req = 1'b0; imem_ack = 1'b0;
    check("t4_after_req",   32'(imem_req),    32'd0);
    check("t4_after_instr", 32'(instruction), 32'd0);
    check("t4_after_vld",   32'(instr_valid), 32'd0);
    check("t4_after_pc",    32'(pc),          32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
